sram_sync: RTL
==============

Name: sram_sync

Overview:
- Parametrised synchronous successor to the lab asynchronous SRAM model.
- Single-port, clocked memory with per-byte write enables, a configurable read pipeline (1 or 2 cycles), and a hardware zero-fill sequencer after reset.
- Sits behind the lab bus/CPU datapath as main data store.
- Same active-low chip-enable/write-enable access convention as the existing SRAM.

Parameters:
- AddressSize, 18, address bits; depth = 2^AddressSize words.
- WordSize, 8, data bits; must be a multiple of 8.
- ReadLatency, 1, clock edges from the access-sampling edge to OutValid; legal values 1 or 2.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
- Address  input  AddressSize  word address, sampled on Clk when an access is accepted.
- InData  input  WordSize  write data.
- bBE  input  WordSize/8  active-low byte-lane enables for writes; bit i covers InData[8i+7:8i]; ignored on reads.
- bCE  input  1  active-low chip enable.
- bWE  input  1  active-low write enable; 1 = read, 0 = write.
- OutData  output  WordSize  read data; holds last read value between reads.
- OutValid  output  1  one-cycle pulse: OutData carries a new read result.
- Ready  output  1  high when accesses are accepted; low during zero-fill.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high.
- Reset values:
  - OutData = 0, OutValid = 0, Ready = 0.
  - Read pipeline flushed.
  - FSM enters FILL with fill counter = 0.
  - Memory array contents are not reset directly; FILL clears them.
- FSM states:
  - FILL:
    - Each cycle writes all-zero to mem[counter], then counter++.
    - On the cycle that writes address 2^AddressSize-1, go to RUN.
    - Ready goes high on the following edge.
    - Fill takes exactly 2^AddressSize cycles after Reset deasserts.
  - RUN:
    - Ready = 1.
    - Remains in RUN until Reset is asserted.
- Access acceptance:
  - An access is accepted on a rising edge where Ready=1 and bCE=0.
  - With bCE=1, or Ready=0, the edge is a no-op: memory unchanged, no OutValid.
  - Accesses presented during FILL are dropped. They are not queued.
- Write (bWE=0):
  - On the accepting edge, each lane i with bBE[i]=0 takes the new InData byte.
  - Lanes with bBE[i]=1 keep their value.
  - All bBE high = no-op write, still legal.
  - Writes produce no OutValid and do not change OutData.
- Read (bWE=1):
  - mem[Address] is sampled on the accepting edge.
  - ReadLatency=1: OutData/OutValid update on that same edge (registered output; visible the cycle after the request).
  - ReadLatency=2: one extra register stage, so update one edge later.
  - Back-to-back reads are accepted every cycle: fully pipelined, no bubbles, results in request order.
  - OutValid is high for exactly one cycle per accepted read.
- Read-after-write to the same address on consecutive accepted edges returns the new data. No hazard; the write completes on its own edge.
- Reset mid-operation:
  - In-flight reads are discarded; no OutValid appears after Reset.
  - An in-progress FILL restarts from address 0.
- Out-of-range Address is impossible, since depth is a full power of two.

Optional Feature:
- Macro: SRAM_PARITY_EN.
- When defined:
  - Each stored byte carries an even-parity bit, written on every byte write (including FILL, parity 0).
  - Reads recompute parity.
  - Added output ParityErr (1 bit, reset 0) pulses with OutValid when any lane of the read word mismatches.
  - Added input InjectErr (1 bit): when high during a write, the stored parity of each written lane is inverted, for test.
- When undefined: no parity storage, no ParityErr/InjectErr ports; behaviour otherwise identical.

Test Plan:
- Fill: AddressSize=4; deassert Reset -> Ready low for exactly 16 cycles, then high; reads of addr 0..15 all return 0x00.
- Write then read, WordSize=32, ReadLatency=1: write 0xDEADBEEF to addr 5 with bBE=4'b0000, then read addr 5 -> OutData=0xDEADBEEF with OutValid on the next edge.
- Byte lanes: over 0xDEADBEEF at addr 5, write 0x11223344 with bBE=4'b1010 -> read returns 0xDE22BE44.
- Pipelined reads, ReadLatency=2: reads of addrs 1, 2, 3 on consecutive edges (holding 0xA1, 0xA2, 0xA3) -> OutValid high 3 consecutive cycles, 2 edges after each request, data A1, A2, A3 in order.
- Drop and disable: a write of 0x55 to addr 3 issued during FILL, and a read with bCE=1 -> addr 3 reads 0x00 after fill; no OutValid for the bCE=1 cycle.
- Reset mid-read, ReadLatency=2: assert Reset the edge after a read request -> no OutValid, OutData=0, Ready=0, fill restarts. With SRAM_PARITY_EN, a write with InjectErr=1 then read -> ParityErr=1 with OutValid.

Source files
------------

// File: rtl/sram_sync.sv
// Single-port synchronous SRAM: per-byte write enables, 1- or 2-cycle read pipeline and a
// zero-fill sequencer after reset. Define SRAM_PARITY_EN for per-byte even-parity checking.
module sram_sync #(
    parameter int AddressSize = 18,
    parameter int WordSize    = 8,
    parameter int ReadLatency = 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [AddressSize-1:0]  Address,
    input  logic [WordSize-1:0]     InData,
    input  logic [WordSize/8-1:0]   bBE,
    input  logic                    bCE,
    input  logic                    bWE,
    output logic [WordSize-1:0]     OutData,
    output logic                    OutValid,
`ifdef SRAM_PARITY_EN
    output logic                    ParityErr,
    input  logic                    InjectErr,
`endif
    output logic                    Ready
);

    // state | meaning
    // FILL  | writing zero to mem[fill_addr] every cycle, accesses dropped
    // RUN   | accesses accepted when bCE is low
    localparam logic [0:0] StFill = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    localparam int Lanes = WordSize / 8;
    localparam int Depth = 2 ** AddressSize;

    logic [WordSize-1:0]    mem [Depth];
    logic [0:0]             state;
    logic [AddressSize-1:0] fill_addr;
    logic                   fill_we;
    logic                   accept;
    logic                   wr_en;
    logic                   rd_en;
    logic [WordSize-1:0]    rd_word;
    logic                   src_valid;
    logic [WordSize-1:0]    src_data;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= StFill;
            fill_addr <= '0;
            Ready     <= 1'b0;
        end else begin
            case (state)
                StFill: begin
                    fill_addr <= fill_addr + 1'b1;
                    if (fill_addr == {AddressSize{1'b1}}) begin
                        state <= StRun;
                        Ready <= 1'b1;
                    end
                end
                StRun: begin
                    Ready <= 1'b1;
                end
                default: begin
                    state <= StFill;
                    Ready <= 1'b0;
                end
            endcase
        end
    end

    // Ready is the registered image of RUN, so it also gates acceptance.
    assign fill_we = (state == StFill) && !Reset;
    assign accept  = Ready && !bCE && !Reset;
    assign wr_en   = accept && !bWE;
    assign rd_en   = accept && bWE;
    assign rd_word = mem[Address];

    always_ff @(posedge Clk) begin
        if (fill_we) begin
            mem[fill_addr] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < Lanes; i++) begin
                if (!bBE[i]) begin
                    mem[Address][8*i +: 8] <= InData[8*i +: 8];
                end
            end
        end
    end

`ifdef SRAM_PARITY_EN
    logic [Lanes-1:0] par_mem [Depth];
    logic [Lanes-1:0] rd_par_calc;
    logic             rd_err;
    logic             src_err;

    always_ff @(posedge Clk) begin
        if (fill_we) begin
            par_mem[fill_addr] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < Lanes; i++) begin
                if (!bBE[i]) begin
                    par_mem[Address][i] <= (^InData[8*i +: 8]) ^ InjectErr;
                end
            end
        end
    end

    always_comb begin
        rd_par_calc = '0;
        for (int i = 0; i < Lanes; i++) begin
            rd_par_calc[i] = ^rd_word[8*i +: 8];
        end
    end

    assign rd_err = |(rd_par_calc ^ par_mem[Address]);
`endif

    generate
        if (ReadLatency == 2) begin : g_lat2
            logic                p_valid;
            logic [WordSize-1:0] p_data;
`ifdef SRAM_PARITY_EN
            logic                p_err;
`endif
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    p_valid <= 1'b0;
                end else begin
                    p_valid <= rd_en;
                end
                if (rd_en) begin
                    p_data <= rd_word;
`ifdef SRAM_PARITY_EN
                    p_err  <= rd_err;
`endif
                end
            end
            assign src_valid = p_valid;
            assign src_data  = p_data;
`ifdef SRAM_PARITY_EN
            assign src_err   = p_err;
`endif
        end else begin : g_lat1
            assign src_valid = rd_en;
            assign src_data  = rd_word;
`ifdef SRAM_PARITY_EN
            assign src_err   = rd_err;
`endif
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            OutData   <= '0;
            OutValid  <= 1'b0;
`ifdef SRAM_PARITY_EN
            ParityErr <= 1'b0;
`endif
        end else begin
            OutValid  <= src_valid;
            if (src_valid) begin
                OutData <= src_data;
            end
`ifdef SRAM_PARITY_EN
            ParityErr <= src_valid && src_err;
`endif
        end
    end

endmodule
